// File: rtl/alu_ex_stage.sv
// Two-stage pipelined ALU execute stage with valid/ready flow control and flush.
// Optional feature: define ALU_OVF_EN to build the registered signed-overflow flag.
module alu_ex_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             inValid,
  output logic             inReady,
  input  logic [2:0]       aluSel,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf
);

  localparam logic [2:0] SEL_AND = 3'b000;
  localparam logic [2:0] SEL_OR  = 3'b001;
  localparam logic [2:0] SEL_ADD = 3'b010;
  localparam logic [2:0] SEL_SUB = 3'b110;
  localparam logic [2:0] SEL_SLT = 3'b111;
  localparam logic [2:0] SEL_NOP = 3'b100;

  logic             r_s1_valid;
  logic [2:0]       r_s1_sel;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;

  logic             w_s2_adv;
  logic             w_s1_adv;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic             w_sub_ovf;
  logic             w_slt;
  logic [WIDTH-1:0] w_alu;

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; a producer holds valid and its payload stable until that edge, and a
  // stage advances only when its holder is empty or is being drained this cycle.
  assign w_s2_adv = !r_s2_valid || outReady;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign inReady  = w_s1_adv && !flush;

  assign w_sum     = r_s1_a + r_s1_b;
  assign w_diff    = r_s1_a - r_s1_b;
  assign w_sub_ovf = (r_s1_a[WIDTH-1] ^ r_s1_b[WIDTH-1]) &
                     (w_diff[WIDTH-1] ^ r_s1_a[WIDTH-1]);
  // Sign of the difference corrected by overflow keeps slt right at the extremes.
  assign w_slt     = w_diff[WIDTH-1] ^ w_sub_ovf;

  always_comb begin
    w_alu = '0;
    case (r_s1_sel)
      SEL_AND: w_alu = r_s1_a & r_s1_b;
      SEL_OR:  w_alu = r_s1_a | r_s1_b;
      SEL_ADD: w_alu = w_sum;
      SEL_SUB: w_alu = w_diff;
      SEL_SLT: w_alu = {{(WIDTH-1){1'b0}}, w_slt};
      default: w_alu = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_sel   <= SEL_NOP;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
    end else if (flush) begin
      r_s1_valid <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_valid <= inValid;
      r_s1_sel   <= aluSel;
      r_s1_a     <= opA;
      r_s1_b     <= opB;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_result   <= '0;
      r_zero     <= 1'b0;
    end else if (flush) begin
      r_s2_valid <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      r_result   <= w_alu;
      r_zero     <= (w_alu == '0);
    end
  end

  assign outValid = r_s2_valid;
  assign result   = r_result;
  assign zero     = r_zero;

`ifdef ALU_OVF_EN
  logic r_ovf;
  logic w_add_ovf;
  logic w_ovf;

  assign w_add_ovf = ~(r_s1_a[WIDTH-1] ^ r_s1_b[WIDTH-1]) &
                     (w_sum[WIDTH-1] ^ r_s1_a[WIDTH-1]);

  always_comb begin
    w_ovf = 1'b0;
    case (r_s1_sel)
      SEL_ADD: w_ovf = w_add_ovf;
      SEL_SUB: w_ovf = w_sub_ovf;
      default: w_ovf = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (!flush && w_s2_adv) begin
      r_ovf <= w_ovf;
    end
  end

  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_alu_ex_stage.sv
// Testbench for alu_ex_stage: vector table, handshake corner sequences, random traffic.
module tb_alu_ex_stage;
  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         inValid;
  logic         inReady;
  logic [2:0]   aluSel;
  logic [W-1:0] opA;
  logic [W-1:0] opB;
  logic         outValid;
  logic         outReady;
  logic [W-1:0] result;
  logic         zero;
  logic         ovf;

  alu_ex_stage #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .inValid(inValid), .inReady(inReady),
    .aluSel(aluSel), .opA(opA), .opB(opB),
    .outValid(outValid), .outReady(outReady),
    .result(result), .zero(zero), .ovf(ovf)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  logic [W+1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  logic         stall_prev = 1'b0;
  logic [W-1:0] p_result;
  logic         p_zero;
  logic         p_ovf;
  logic         s_in_ready;
  logic         s_out_valid;
  logic         acc;

  typedef struct {
    logic [2:0]   sel;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         z;
    logic         ov;
  } vec_t;
  vec_t vecs[14];

  function automatic logic gate_ovf(input logic raw);
`ifdef ALU_OVF_EN
    return raw;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [W+1:0] ref_alu(input logic [2:0] s, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [W-1:0] r;
    logic         o;
    longint       sa, sb, t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = '0;
    o  = 1'b0;
    case (s)
      3'b000: r = a & b;
      3'b001: r = a | b;
      3'b010: begin
        r = a + b;
        t = sa + sb;
        o = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      3'b110: begin
        r = a - b;
        t = sa - sb;
        o = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      3'b111: r = (sa < sb) ? 32'd1 : 32'd0;
      default: r = '0;
    endcase
    return {r, (r == '0), gate_ovf(o)};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver: one clock cycle, starting at a negedge ----------------
  task automatic cycle(input logic v, input logic [2:0] s, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W+1:0] e,
                       input logic ordy, input logic fl, output logic accepted);
    logic [W+1:0] x;
    inValid  = v;
    aluSel   = s;
    opA      = a;
    opB      = b;
    outReady = ordy;
    flush    = fl;
    #1;
    s_in_ready  = inReady;
    s_out_valid = outValid;
    if (stall_prev) begin
      check("hold_valid", W'(outValid), W'(1'b1));
      check("hold_result", result, p_result);
      check("hold_zero", W'(zero), W'(p_zero));
      check("hold_ovf", W'(ovf), W'(p_ovf));
    end
    accepted = inValid && inReady;
    if (accepted) exp_q.push_back(e);
    if (outValid && outReady && !fl) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_unexpected: got result %h with nothing expected", result);
      end else begin
        x = exp_q.pop_front();
        check("sb_result", result, x[W+1:2]);
        check("sb_zero", W'(zero), W'(x[1]));
        check("sb_ovf", W'(ovf), W'(x[0]));
      end
    end
    stall_prev = outValid && !outReady && !fl;
    p_result   = result;
    p_zero     = zero;
    p_ovf      = ovf;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy);
    logic a;
    cycle(1'b0, 3'b100, '0, '0, '0, ordy, 1'b0, a);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) idle(1'b1);
    check("drain_empty", W'(exp_q.size()), W'(0));
  endtask

  task automatic do_reset(input logic fl);
    rst      = 1'b1;
    flush    = fl;
    inValid  = 1'b0;
    outReady = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst   = 1'b0;
    flush = 1'b0;
    #1;
    check("rst_outValid", W'(outValid), W'(1'b0));
    check("rst_result", result, '0);
    check("rst_zero", W'(zero), W'(1'b0));
    check("rst_ovf", W'(ovf), W'(1'b0));
    check("rst_inReady", W'(inReady), W'(1'b1));
    exp_q.delete();
    stall_prev = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [2:0]   rs;
    logic [W-1:0] ra, rb;
    logic         rv, ro;
    int           bp_idx;

    rst = 1'b1; flush = 1'b0; inValid = 1'b0; outReady = 1'b0;
    aluSel = 3'b100; opA = '0; opB = '0;

    vecs[0]  = '{3'b010, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1'b0, 1'b0};
    vecs[1]  = '{3'b110, 32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 1'b1, 1'b0};
    vecs[2]  = '{3'b111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0};
    vecs[3]  = '{3'b001, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0, 1'b0};
    vecs[4]  = '{3'b111, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b0};
    vecs[5]  = '{3'b010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1};
    vecs[6]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0};
    vecs[7]  = '{3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0};
    vecs[8]  = '{3'b100, 32'h0000_0012, 32'h0000_0034, 32'h0000_0000, 1'b1, 1'b0};
    vecs[9]  = '{3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0};
    vecs[10] = '{3'b110, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1};
    vecs[11] = '{3'b110, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[12] = '{3'b111, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0};
    vecs[13] = '{3'b010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0};

    do_reset(1'b0);

    // Single add: latency of two cycles after the accepting cycle.
    cycle(1'b1, vecs[0].sel, vecs[0].a, vecs[0].b,
          {vecs[0].res, vecs[0].z, gate_ovf(vecs[0].ov)}, 1'b1, 1'b0, acc);
    check("lat_accept", W'(acc), W'(1'b1));
    idle(1'b1);
    check("lat_n1_outValid", W'(s_out_valid), W'(1'b0));
    idle(1'b1);
    check("lat_n2_outValid", W'(s_out_valid), W'(1'b1));
    drain();

    // Full table back to back: one acceptance per cycle.
    foreach (vecs[i]) begin
      cycle(1'b1, vecs[i].sel, vecs[i].a, vecs[i].b,
            {vecs[i].res, vecs[i].z, gate_ovf(vecs[i].ov)}, 1'b1, 1'b0, acc);
      check("tput_accept", W'(acc), W'(1'b1));
    end
    drain();

    // Back-pressure: exactly two absorbed, then inReady drops until outReady rises.
    bp_idx = 1;
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, vecs[bp_idx].sel, vecs[bp_idx].a, vecs[bp_idx].b,
            {vecs[bp_idx].res, vecs[bp_idx].z, gate_ovf(vecs[bp_idx].ov)}, 1'b0, 1'b0, acc);
      check("bp_inReady", W'(s_in_ready), (k < 2) ? W'(1) : W'(0));
      if (acc) bp_idx++;
    end
    check("bp_absorbed", W'(bp_idx - 1), W'(2));
    cycle(1'b1, vecs[bp_idx].sel, vecs[bp_idx].a, vecs[bp_idx].b,
          {vecs[bp_idx].res, vecs[bp_idx].z, gate_ovf(vecs[bp_idx].ov)}, 1'b1, 1'b0, acc);
    check("bp_reassert", W'(s_in_ready), W'(1'b1));
    drain();

    // Flush with both stages full.
    cycle(1'b1, vecs[9].sel, vecs[9].a, vecs[9].b, '0, 1'b0, 1'b0, acc);
    cycle(1'b1, vecs[10].sel, vecs[10].a, vecs[10].b, '0, 1'b0, 1'b0, acc);
    cycle(1'b1, vecs[11].sel, vecs[11].a, vecs[11].b, '0, 1'b0, 1'b1, acc);
    check("flush_inReady", W'(s_in_ready), W'(1'b0));
    exp_q.delete();
    idle(1'b1);
    check("flush_outValid", W'(s_out_valid), W'(1'b0));
    cycle(1'b1, vecs[12].sel, vecs[12].a, vecs[12].b,
          {vecs[12].res, vecs[12].z, gate_ovf(vecs[12].ov)}, 1'b1, 1'b0, acc);
    check("post_flush_accept", W'(acc), W'(1'b1));
    idle(1'b1);
    check("post_flush_n1", W'(s_out_valid), W'(1'b0));
    idle(1'b1);
    check("post_flush_n2", W'(s_out_valid), W'(1'b1));
    drain();

    // Reset mid-stream, then reset together with flush.
    cycle(1'b1, vecs[5].sel, vecs[5].a, vecs[5].b, '0, 1'b0, 1'b0, acc);
    cycle(1'b1, vecs[3].sel, vecs[3].a, vecs[3].b, '0, 1'b0, 1'b0, acc);
    do_reset(1'b0);
    idle(1'b1);
    check("rst_no_partial", W'(s_out_valid), W'(1'b0));
    cycle(1'b1, vecs[2].sel, vecs[2].a, vecs[2].b, '0, 1'b0, 1'b0, acc);
    cycle(1'b1, vecs[4].sel, vecs[4].a, vecs[4].b, '0, 1'b0, 1'b0, acc);
    do_reset(1'b1);
    idle(1'b1);
    check("rstfl_no_partial", W'(s_out_valid), W'(1'b0));

    // Random traffic with random back-pressure; upstream holds an op until taken.
    rv = 1'b0; rs = 3'b000; ra = '0; rb = '0;
    for (int n = 0; n < 120; n++) begin
      if (!rv || acc) begin
        rv = ($urandom_range(0, 3) != 0);
        rs = 3'($urandom_range(0, 7));
        ra = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom;
        rb = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
      end
      ro = ($urandom_range(0, 3) != 0);
      cycle(rv, rs, ra, rb, ref_alu(rs, ra, rb), ro, 1'b0, acc);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
